// File: rtl/uart_host_arbiter.sv
// rtl/uart_host_arbiter.sv - round-robin TX / polled RX sequencer, sole master of the UART register port
// Optional RX draining is built only when UART_ARB_RX_POLL_EN is defined.
module uart_host_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter int          ID_W      = 2,
    parameter logic [7:0]  CTRL_ADDR = 8'd1,
    parameter logic [7:0]  BUF_ADDR  = 8'd2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [7:0]           u_addr,
    output logic [7:0]           u_din,
    output logic                 u_w_en,
    output logic                 u_r_en,
    input  logic [7:0]           u_dout,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        POLL_RD,
        POLL_WAIT,
`ifdef UART_ARB_RX_POLL_EN
        TX_WR,
        RX_RD,
        RX_WAIT
`else
        TX_WR
`endif
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] ptr_next;
    logic [7:0]      win_data;
    logic            found;
    logic            any_req;
    logic            wake;
    logic            unused_in;

    assign any_req  = |req_valid;
    assign ptr_next = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

`ifdef UART_ARB_RX_POLL_EN
    assign wake      = any_req || !rx_valid;
    assign unused_in = ^u_dout[7:2];
`else
    assign wake      = any_req;
    assign rx_data   = 8'h00;
    assign rx_valid  = 1'b0;
    assign unused_in = ^{u_dout[7:2], u_dout[0], rx_ready};
`endif

    // First valid requester at or above ptr, wrapping at NUM_REQ-1.
    always_comb begin
        logic [ID_W:0]   s;
        logic [ID_W-1:0] j;
        found    = 1'b0;
        winner   = ptr;
        win_data = 8'h00;
        s        = '0;
        j        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            s = {1'b0, ptr} + (ID_W+1)'(i);
            if (s >= (ID_W+1)'(NUM_REQ))
                s = s - (ID_W+1)'(NUM_REQ);
            j = s[ID_W-1:0];
            if (!found && req_valid[j]) begin
                found    = 1'b1;
                winner   = j;
                win_data = req_data[{j, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            req_ready <= '0;
            u_addr    <= '0;
            u_din     <= '0;
            u_w_en    <= 1'b0;
            u_r_en    <= 1'b0;
            grant_id  <= '0;
            busy      <= 1'b0;
`ifdef UART_ARB_RX_POLL_EN
            rx_data   <= '0;
            rx_valid  <= 1'b0;
`endif
        end else begin
            // Strobes and address are single-cycle; each state re-asserts what it needs.
            req_ready <= '0;
            u_addr    <= '0;
            u_w_en    <= 1'b0;
            u_r_en    <= 1'b0;
`ifdef UART_ARB_RX_POLL_EN
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (wake) begin
                        state  <= POLL_RD;
                        u_addr <= CTRL_ADDR;
                        u_r_en <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                POLL_RD: state <= POLL_WAIT;
                POLL_WAIT: begin
`ifdef UART_ARB_RX_POLL_EN
                    if (u_dout[0] && !rx_valid) begin
                        state  <= RX_RD;
                        u_addr <= BUF_ADDR;
                        u_r_en <= 1'b1;
                    end else
`endif
                    if (u_dout[1] && any_req) begin
                        state     <= TX_WR;
                        u_addr    <= BUF_ADDR;
                        u_din     <= win_data;
                        u_w_en    <= 1'b1;
                        req_ready <= NUM_REQ'(1) << winner;
                        grant_id  <= winner;
                        ptr       <= ptr_next;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                TX_WR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef UART_ARB_RX_POLL_EN
                RX_RD: state <= RX_WAIT;
                RX_WAIT: begin
                    rx_data  <= u_dout;
                    rx_valid <= 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
